// File: rtl/sub_bytes_sched.sv
// ============================================================================
//  Module   : sub_bytes_sched
//  Purpose  : Time-shares one 4-lane S-box bank between a 128-bit cipher-state
//             SubBytes request and a 32-bit key-expansion SubWord request.
//             Optional macro SUB_BYTES_SCHED_KEY_PRIO_EN gives the key side
//             strict priority instead of round-robin arbitration.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sub_bytes_sched (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_valid,
    output logic         st_ready,
    input  logic [127:0] st_in,
    output logic         st_done,
    output logic [127:0] st_out,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [31:0]  key_in,
    output logic         key_done,
    output logic [31:0]  key_out,
    output logic [31:0]  sb_in,
    input  logic [31:0]  sb_out,
    output logic         busy
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_SUB  = 2'd1;
    localparam logic [1:0] c_KEY_SUB = 2'd2;

    logic [1:0]   r_state;
    logic [1:0]   w_nextState;
    logic [1:0]   r_cnt;
    logic [127:0] r_work;
    logic [95:0]  r_acc;
    logic [31:0]  w_stWord;
    logic         w_grantSt;
    logic         w_grantKey;
    logic         w_idle;

`ifndef SUB_BYTES_SCHED_KEY_PRIO_EN
    localparam logic c_GRANT_ST  = 1'b0;
    localparam logic c_GRANT_KEY = 1'b1;
    logic r_lastGrant;
`endif

    assign w_idle = (r_state == c_IDLE) && !rst;

    // Grants are mutually exclusive; the state requester only wins a
    // contention when the key side (or nobody) was served last.
`ifdef SUB_BYTES_SCHED_KEY_PRIO_EN
    assign w_grantKey = w_idle && key_valid;
    assign w_grantSt  = w_idle && st_valid && !key_valid;
`else
    assign w_grantSt  = w_idle && st_valid && (!key_valid || (r_lastGrant == c_GRANT_KEY));
    assign w_grantKey = w_idle && key_valid && !w_grantSt;
`endif

    always_comb begin
        w_stWord = r_work[127:96];
        case (r_cnt)
            2'd0:    w_stWord = r_work[127:96];
            2'd1:    w_stWord = r_work[95:64];
            2'd2:    w_stWord = r_work[63:32];
            default: w_stWord = r_work[31:0];
        endcase
    end

    always_comb begin
        w_nextState = r_state;
        sb_in       = 32'h0;
        st_ready    = 1'b0;
        key_ready   = 1'b0;
        busy        = (r_state != c_IDLE);
        case (r_state)
            c_IDLE: begin
                st_ready  = w_grantSt;
                key_ready = w_grantKey;
                if (w_grantSt)
                    w_nextState = c_ST_SUB;
                else if (w_grantKey)
                    w_nextState = c_KEY_SUB;
            end
            c_ST_SUB: begin
                sb_in = w_stWord;
                if (r_cnt == 2'd3)
                    w_nextState = c_IDLE;
            end
            c_KEY_SUB: begin
                sb_in       = r_work[31:0];
                w_nextState = c_IDLE;
            end
            default: w_nextState = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= 2'd0;
            st_out      <= 128'h0;
            key_out     <= 32'h0;
            st_done     <= 1'b0;
            key_done    <= 1'b0;
`ifndef SUB_BYTES_SCHED_KEY_PRIO_EN
            r_lastGrant <= c_GRANT_KEY;
`endif
        end else begin
            r_state  <= w_nextState;
            st_done  <= 1'b0;
            key_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_grantSt) begin
                        r_work      <= st_in;
                        r_cnt       <= 2'd0;
`ifndef SUB_BYTES_SCHED_KEY_PRIO_EN
                        r_lastGrant <= c_GRANT_ST;
`endif
                    end else if (w_grantKey) begin
                        r_work      <= {96'h0, key_in};
`ifndef SUB_BYTES_SCHED_KEY_PRIO_EN
                        r_lastGrant <= c_GRANT_KEY;
`endif
                    end
                end
                c_ST_SUB: begin
                    r_cnt <= r_cnt + 2'd1;
                    // Words 0..2 are staged so st_out never shows a partial result.
                    case (r_cnt)
                        2'd0: r_acc[95:64] <= sb_out;
                        2'd1: r_acc[63:32] <= sb_out;
                        2'd2: r_acc[31:0]  <= sb_out;
                        default: begin
                            st_out  <= {r_acc, sb_out};
                            st_done <= 1'b1;
                        end
                    endcase
                end
                c_KEY_SUB: begin
                    key_out  <= sb_out;
                    key_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sub_bytes_sched.sv
// ============================================================================
//  Module   : tb_sub_bytes_sched
//  Purpose  : Directed self-checking bench for sub_bytes_sched with an AES
//             S-box bank model on sb_in/sb_out.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sub_bytes_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         st_valid;
    logic         st_ready;
    logic [127:0] st_in;
    logic         st_done;
    logic [127:0] st_out;
    logic         key_valid;
    logic         key_ready;
    logic [31:0]  key_in;
    logic         key_done;
    logic [31:0]  key_out;
    logic [31:0]  sb_in;
    logic [31:0]  sb_out;
    logic         busy;

    int errCnt = 0;
    int chkCnt = 0;

    sub_bytes_sched u_dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_in     (st_in),
        .st_done   (st_done),
        .st_out    (st_out),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_in    (key_in),
        .key_done  (key_done),
        .key_out   (key_out),
        .sb_in     (sb_in),
        .sb_out    (sb_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h0;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h0;
        for (int y = 1; y < 256; y++)
            if (x != 8'h0 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    always_comb
        sb_out = {sbox(sb_in[31:24]), sbox(sb_in[23:16]), sbox(sb_in[15:8]), sbox(sb_in[7:0])};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        chkCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Starts in an IDLE cycle; returns in the st_done cycle.
    task automatic runSt(input logic [127:0] din, input logic [127:0] exp, input string tag);
        st_in    = din;
        st_valid = 1'b1;
        #1 chk({tag, " st_ready"}, st_ready, 1'b1);
        tick;
        st_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk({tag, " sb_in"}, sb_in, din[127-32*k -: 32]);
            chk({tag, " st_done early"}, st_done, 1'b0);
            tick;
        end
        chk({tag, " st_done"}, st_done, 1'b1);
        chk({tag, " st_out"}, st_out, exp);
        chk({tag, " busy"}, busy, 1'b0);
    endtask

    task automatic runKey(input logic [31:0] din, input logic [31:0] exp, input string tag);
        key_in    = din;
        key_valid = 1'b1;
        #1 chk({tag, " key_ready"}, key_ready, 1'b1);
        tick;
        key_valid = 1'b0;
        chk({tag, " sb_in"}, sb_in, din);
        chk({tag, " key_done early"}, key_done, 1'b0);
        tick;
        chk({tag, " key_done"}, key_done, 1'b1);
        chk({tag, " key_out"}, key_out, exp);
    endtask

    localparam logic [127:0] c_ALL63 = {16{8'h63}};
    localparam logic [127:0] c_VEC2  = 128'h00102030_40506070_8090a0b0_c0d0e0f0;
    localparam logic [127:0] c_EXP2  = 128'h63cab704_0953d051_cd60e0e7_ba70e18c;
    localparam logic [127:0] c_VEC3  = 128'h01020300_ff000000_53535353_00000000;
    localparam logic [127:0] c_EXP3  = 128'h7c777b63_16636363_edededed_63636363;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; st_valid = 1'b0; key_valid = 1'b0;
        st_in = '0; key_in = '0;
        tick; tick;
        st_valid = 1'b1; key_valid = 1'b1;
        #1 chk("rst st_ready", st_ready, 1'b0);
        chk("rst key_ready", key_ready, 1'b0);
        tick;
        chk("rst busy", busy, 1'b0);
        chk("rst st_out", st_out, '0);
        chk("rst key_out", key_out, '0);
        chk("rst st_done", st_done, 1'b0);
        chk("rst key_done", key_done, 1'b0);
        chk("rst sb_in", sb_in, '0);

        rst = 1'b0; st_in = '0; key_in = 32'h00010053;
        #1;
`ifndef SUB_BYTES_SCHED_KEY_PRIO_EN
        chk("cont1 st_ready", st_ready, 1'b1);
        chk("cont1 key_ready", key_ready, 1'b0);
        tick;
        st_valid = 1'b0;
        chk("cont1 busy", busy, 1'b1);
        chk("cont1 key ignored", key_ready, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("zero sb_in", sb_in, '0);
            chk("zero st_done early", st_done, 1'b0);
            tick;
        end
        chk("zero st_done", st_done, 1'b1);
        chk("zero st_out", st_out, c_ALL63);
        st_valid = 1'b1; st_in = c_VEC2;
        #1 chk("cont2 st_ready", st_ready, 1'b0);
        chk("cont2 key_ready", key_ready, 1'b1);
        tick;
        key_valid = 1'b0;
        chk("key1 sb_in", sb_in, 32'h00010053);
        chk("key1 key_done early", key_done, 1'b0);
        tick;
        chk("key1 key_done", key_done, 1'b1);
        chk("key1 key_out", key_out, 32'h637C63ED);
        chk("key1 st_done", st_done, 1'b0);
        chk("cont2 late st_ready", st_ready, 1'b1);
        tick;
        st_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("vec2 sb_in", sb_in, c_VEC2[127-32*k -: 32]);
            tick;
        end
        chk("vec2 st_done", st_done, 1'b1);
        chk("vec2 st_out", st_out, c_EXP2);
`else
        chk("prio key_ready", key_ready, 1'b1);
        chk("prio st_ready", st_ready, 1'b0);
        tick;
        key_valid = 1'b0;
        chk("prio sb_in", sb_in, 32'h00010053);
        tick;
        chk("prio key_done", key_done, 1'b1);
        chk("prio key_out", key_out, 32'h637C63ED);
        chk("prio st_ready", st_ready, 1'b1);
        tick;
        st_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("prio zero sb_in", sb_in, '0);
            tick;
        end
        chk("prio st_done", st_done, 1'b1);
        chk("prio st_out", st_out, c_ALL63);
`endif

        // Back-to-back: second request accepted in the first one's done cycle.
        runSt(c_VEC3, c_EXP3, "b2b1");
        runSt(c_VEC2, c_EXP2, "b2b2");
        runKey(32'h10ff0130, 32'hca167c04, "key2");

        tick;
        chk("key2 pulse", key_done, 1'b0);
        st_in = c_VEC3; st_valid = 1'b1;
        #1 chk("abort st_ready", st_ready, 1'b1);
        tick;
        st_valid = 1'b0;
        chk("abort busy", busy, 1'b1);
        tick;
        rst = 1'b1;
        tick;
        st_valid = 1'b1;
        #1 chk("abort rst st_ready", st_ready, 1'b0);
        st_valid = 1'b0; rst = 1'b0;
        chk("abort busy", busy, 1'b0);
        chk("abort st_out", st_out, '0);
        for (int k = 0; k < 6; k++) begin
            chk("abort no st_done", st_done, 1'b0);
            tick;
        end
        runKey(32'h00010053, 32'h637C63ED, "key3");

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sub_bytes_sched.md
SUB_BYTES_SCHED -- requirements
Module: sub_bytes_sched

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: st_valid  input  1  cipher-state request valid.
REQ-004 SHALL have ports: st_ready  output  1  cipher-state request accepted this cycle when high with st_valid.
REQ-005 SHALL have ports: st_in  input  128  state to substitute; bits [127:120] are byte 0.
REQ-006 SHALL have ports: st_done  output  1  one-cycle pulse, st_out valid.
REQ-007 SHALL have ports: st_out  output  128  substituted state; holds until next st_done.
REQ-008 SHALL have ports: key_valid  input  1  key-expansion word request valid.
REQ-009 SHALL have ports: key_ready  output  1  key word accepted this cycle when high with key_valid.
REQ-010 SHALL have ports: key_in  input  32  key word to substitute.
REQ-011 SHALL have ports: key_done  output  1  one-cycle pulse, key_out valid.
REQ-012 SHALL have ports: key_out  output  32  substituted key word; holds until next key_done.
REQ-013 SHALL have ports: sb_in  output  32  drive to shared 4-S-box bank (4 independent byte lanes).
REQ-014 SHALL have ports: sb_out  input  32  combinational S-box bank result for sb_in, same cycle.
REQ-015 SHALL have ports: busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ST_SUB, KEY_SUB.
REQ-017 SHALL assert st_ready/key_ready only in IDLE with rst low, to at most one requester (the granted one), combinationally from valids and state.
REQ-018 SHALL arbitrate round-robin: both valid -> grant requester not served last; last_grant resets to KEY, so state wins first contention.
REQ-019 SHALL, on accept, capture the request data into a working register and go to ST_SUB (2-bit counter cleared) or KEY_SUB.
REQ-020 SHALL, in ST_SUB, drive sb_in = working[127-32*cnt -: 32], write sb_out into result word cnt, increment cnt; at cnt==3 return to IDLE.
REQ-021 SHALL, in KEY_SUB, drive sb_in = working key word, register sb_out, return to IDLE.
REQ-022 SHALL drive sb_in = 32'h0 in IDLE.
REQ-023 SHALL give latency: state accepted cycle T -> substitution T+1..T+4, st_done at T+5; key accepted T -> key_done at T+2.
REQ-024 SHALL register st_out/st_done and key_out/key_done so done coincides with IDLE; a new request may be accepted in the st_done/key_done cycle.
REQ-025 SHALL ignore valids while busy; requester holds valid and data until ready.
REQ-026 SHALL never assert st_done and key_done in the same cycle.

Reset
REQ-027 SHALL, with rst high at a clock edge, force IDLE, cnt=0, last_grant=KEY, st_out=0, key_out=0, st_done=0, key_done=0; st_ready=key_ready=0 while rst high.
REQ-028 SHALL abort any in-flight operation on reset with no done pulse and no partial result on st_out/key_out.

Configuration
REQ-029 SHALL, with macro SUB_BYTES_SCHED_KEY_PRIO_EN defined, grant key requester strict priority whenever key_valid is high in IDLE; last_grant unused.
REQ-030 SHALL, without SUB_BYTES_SCHED_KEY_PRIO_EN, use round-robin per REQ-018.

Verification
REQ-031 SHALL cover: st_in=128'h0 accepted at T -> sb_in four words of 0 at T+1..T+4, st_done at T+5, st_out=128'h6363...63.
REQ-032 SHALL cover: key_in=32'h00010053 accepted at T -> key_done at T+2, key_out=32'h637C63ED.
REQ-033 SHALL cover: st_valid and key_valid both high first cycle after reset -> state accepted T, key accepted T+5, key_done T+7; next contention grants key first.
REQ-034 SHALL cover: rst high at T+2 of state op -> no st_done, st_out=0, busy=0, then a new key request completes normally.
REQ-035 SHALL cover: back-to-back state requests -> second accepted on first's st_done cycle, st_done pulses 5 cycles apart.
REQ-036 SHALL cover: with SUB_BYTES_SCHED_KEY_PRIO_EN, simultaneous valids after reset -> key accepted first, key_done T+2, state accepted T+2.
